two_way_demux_buf: RTL and testbench

Buffered 1-to-2 demultiplexer that steers a single valid/ready input stream into one of two output channels, selected per beat by `in_sel`. It sits on the result path of the approximate-multiplier datapath, downstream of the 2:1 select logic. It distributes computed words to two consumers: channel 1 for the exact path and channel 2 for the approximate path. Each output channel has its own 2-entry FIFO, so one stalled consumer does not block beats addressed to the other.

---
 rtl/two_way_demux_buf.sv | 152 +++++++++++++++
 tb/tb_two_way_demux_buf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/two_way_demux_buf.sv
// two_way_demux_buf
// Buffered 1-to-2 demultiplexer for the approximate-multiplier result path.
// One valid/ready input stream is steered per beat by in_sel into one of two
// output channels (channel 1: exact path, channel 2: approximate path). Each
// channel owns a 2-entry FIFO, so a stalled consumer never blocks beats that
// are addressed to the other channel.
//
// Optional feature macro: DEMUX_COUNT_EN
//   defined   -> cnt1/cnt2 ports exist; each counts delivered beats (pops) of
//                its channel, saturating at 255, cleared only by reset.
//   undefined -> counter ports and logic are absent.

module two_way_demux_buf #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_sel,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef DEMUX_COUNT_EN
   ,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2
`endif
);

   // Per-channel FIFO occupancy states.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   // Per-channel views, index 0 = channel 1, index 1 = channel 2.
   logic [1:0]       w_full;
   logic [1:0]       w_push;
   logic [1:0]       w_pop;
   logic [1:0]       w_out_ready;
   logic [1:0]       w_out_valid;
   logic [WIDTH-1:0] w_out_data [2];
`ifdef DEMUX_COUNT_EN
   logic [7:0]       w_cnt [2];
`endif

   assign w_out_ready = {out2_ready, out1_ready};

   // Ready depends only on the addressed FIFO's state. A pop in the same
   // cycle does not free space until the next edge (no pass-through), which
   // keeps in_ready free of any combinational path from outN_ready.
   assign in_ready = in_sel ? ~w_full[1] : ~w_full[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         occ_t             r_occ;
         logic             r_wr_ptr;
         logic             r_rd_ptr;
         logic [WIDTH-1:0] r_mem [2];

         // Channel gi is addressed when in_sel equals its index.
         assign w_push[gi]      = in_valid && in_ready && (in_sel == (gi != 0));
         assign w_pop[gi]       = w_out_valid[gi] && w_out_ready[gi];
         assign w_full[gi]      = (r_occ == OCC_FULL);
         assign w_out_valid[gi] = (r_occ != OCC_EMPTY);
         // Head word comes straight from registered storage, so it is stable
         // for as long as the consumer stalls.
         assign w_out_data[gi]  = r_mem[r_rd_ptr];

         // Occupancy FSM plus read/write pointers; push and pop in ONE cancel.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_occ    <= OCC_EMPTY;
               r_wr_ptr <= 1'b0;
               r_rd_ptr <= 1'b0;
            end else begin
               if (w_push[gi]) begin
                  r_wr_ptr <= ~r_wr_ptr;
               end
               if (w_pop[gi]) begin
                  r_rd_ptr <= ~r_rd_ptr;
               end
               case (r_occ)
                  OCC_EMPTY: begin
                     if (w_push[gi]) begin
                        r_occ <= OCC_ONE;
                     end
                  end
                  OCC_ONE: begin
                     if (w_push[gi] && !w_pop[gi]) begin
                        r_occ <= OCC_FULL;
                     end else if (!w_push[gi] && w_pop[gi]) begin
                        r_occ <= OCC_EMPTY;
                     end
                  end
                  OCC_FULL: begin
                     if (w_pop[gi]) begin
                        r_occ <= OCC_ONE;
                     end
                  end
                  default: begin
                     r_occ <= OCC_EMPTY;
                  end
               endcase
            end
         end

         // Storage write; cleared on reset so the data outputs read zero.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_mem[0] <= '0;
               r_mem[1] <= '0;
            end else if (w_push[gi]) begin
               r_mem[r_wr_ptr] <= in_data;
            end
         end

`ifdef DEMUX_COUNT_EN
         logic [7:0] r_cnt;

         // Delivered-beat counter, saturating at 255.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= 8'd0;
            end else if (w_pop[gi] && (r_cnt != 8'hFF)) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end

         assign w_cnt[gi] = r_cnt;
`endif
      end
   endgenerate

   assign out1_valid = w_out_valid[0];
   assign out1_data  = w_out_data[0];
   assign out2_valid = w_out_valid[1];
   assign out2_data  = w_out_data[1];

`ifdef DEMUX_COUNT_EN
   assign cnt1 = w_cnt[0];
   assign cnt2 = w_cnt[1];
`endif

endmodule

// File: tb/tb_two_way_demux_buf.sv
// tb_two_way_demux_buf
// Self-checking bench for two_way_demux_buf: a directed vector table, hand
// sequences for asynchronous reset and counter saturation (DEMUX_COUNT_EN),
// and a randomized phase checked against a queue-based reference model.

module tb_two_way_demux_buf;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_sel;
   logic             in_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out2_data;
   logic             out2_valid;
   logic             out2_ready;
`ifdef DEMUX_COUNT_EN
   logic [7:0]       cnt1;
   logic [7:0]       cnt2;
`endif

   always #5 clk = ~clk;

   two_way_demux_buf #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sel     (in_sel),
      .in_ready   (in_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready)
`ifdef DEMUX_COUNT_EN
      ,
      .cnt1       (cnt1),
      .cnt2       (cnt2)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reset held across two edges; returns at posedge+1 with rst_n released.
   task automatic do_reset();
      in_valid   = 1'b0;
      in_sel     = 1'b0;
      in_data    = '0;
      out1_ready = 1'b0;
      out2_ready = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r1, input logic r2);
      in_valid   = v;
      in_sel     = s;
      in_data    = d;
      out1_ready = r1;
      out2_ready = r2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed vectors: inputs applied, outputs checked just before the edge.
   typedef struct {
      logic             v;
      logic             s;
      logic [WIDTH-1:0] d;
      logic             r1;
      logic             r2;
      logic             e_rdy;
      logic             e_v1;
      logic [WIDTH-1:0] e_d1;
      logic             e_v2;
      logic [WIDTH-1:0] e_d2;
   } vec_t;

   vec_t tv [14];

   // Reference model: one queue per channel, capacity two.
   logic [WIDTH-1:0] mq1 [$];
   logic [WIDTH-1:0] mq2 [$];
   int               pops1;
   int               pops2;

   task automatic rnd_cycle();
      logic             v, s, r1, r2, e_rdy, push, pop1, pop2;
      logic [WIDTH-1:0] d;
      v  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      d  = WIDTH'($urandom);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 2) == 0);
      drive(v, s, d, r1, r2);
      #2;
      e_rdy = s ? (mq2.size() < 2) : (mq1.size() < 2);
      chk("rnd in_ready", 32'(in_ready), 32'(e_rdy));
      chk("rnd out1_valid", 32'(out1_valid), 32'(mq1.size() > 0));
      chk("rnd out2_valid", 32'(out2_valid), 32'(mq2.size() > 0));
      if (mq1.size() > 0) chk("rnd out1_data", 32'(out1_data), 32'(mq1[0]));
      if (mq2.size() > 0) chk("rnd out2_data", 32'(out2_data), 32'(mq2[0]));
`ifdef DEMUX_COUNT_EN
      chk("rnd cnt1", 32'(cnt1), (pops1 > 255) ? 255 : pops1);
      chk("rnd cnt2", 32'(cnt2), (pops2 > 255) ? 255 : pops2);
`endif
      push = v && e_rdy;
      pop1 = (mq1.size() > 0) && r1;
      pop2 = (mq2.size() > 0) && r2;
      @(posedge clk);
      if (pop1) begin
         void'(mq1.pop_front());
         pops1++;
      end
      if (pop2) begin
         void'(mq2.pop_front());
         pops2++;
      end
      if (push) begin
         if (s) mq2.push_back(d);
         else   mq1.push_back(d);
      end
      #1;
   endtask

   initial begin
      tv[0]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tv[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000};
      tv[2]  = '{1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
      tv[3]  = '{1'b1, 1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hAAAA};
      tv[4]  = '{1'b1, 1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA};
      tv[5]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hAAAA};
      tv[6]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hAAAA};
      tv[7]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'hBBBB};
      tv[8]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
      tv[9]  = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
      tv[10] = '{1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
      tv[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000};
      tv[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000};
      tv[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};

      // ---------------- reset state ----------------
      do_reset();
      #2;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out1_valid", 32'(out1_valid), 32'd0);
      chk("reset out2_valid", 32'(out2_valid), 32'd0);
      chk("reset out1_data", 32'(out1_data), 32'd0);
      chk("reset out2_data", 32'(out2_data), 32'd0);
`ifdef DEMUX_COUNT_EN
      chk("reset cnt1", 32'(cnt1), 32'd0);
      chk("reset cnt2", 32'(cnt2), 32'd0);
`endif
      $display("reset: in_ready=%0b out1_valid=%0b out2_valid=%0b", in_ready, out1_valid, out2_valid);
      tick();

      // ---------------- directed table ----------------
      for (int i = 0; i < 14; i++) begin
         drive(tv[i].v, tv[i].s, tv[i].d, tv[i].r1, tv[i].r2);
         #2;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
         chk($sformatf("vec%0d out1_valid", i), 32'(out1_valid), 32'(tv[i].e_v1));
         chk($sformatf("vec%0d out2_valid", i), 32'(out2_valid), 32'(tv[i].e_v2));
         if (tv[i].e_v1) chk($sformatf("vec%0d out1_data", i), 32'(out1_data), 32'(tv[i].e_d1));
         if (tv[i].e_v2) chk($sformatf("vec%0d out2_data", i), 32'(out2_data), 32'(tv[i].e_d2));
         $display("vec%0d: v=%0b sel=%0b d=%h r1=%0b r2=%0b -> rdy=%0b v1=%0b d1=%h v2=%0b d2=%h",
                  i, tv[i].v, tv[i].s, tv[i].d, tv[i].r1, tv[i].r2,
                  in_ready, out1_valid, out1_data, out2_valid, out2_data);
         tick();
      end

      // ---------------- async reset with both FIFOs full ----------------
      drive(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 16'h2222, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 16'h3333, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      #2;
      chk("full in_ready ch1", 32'(in_ready), 32'd0);
      chk("full out1_valid", 32'(out1_valid), 32'd1);
      chk("full out2_valid", 32'(out2_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async rst out1_valid", 32'(out1_valid), 32'd0);
      chk("async rst out2_valid", 32'(out2_valid), 32'd0);
      chk("async rst out1_data", 32'(out1_data), 32'd0);
      chk("async rst out2_data", 32'(out2_data), 32'd0);
      chk("async rst in_ready", 32'(in_ready), 32'd1);
      $display("async reset: out1_valid=%0b out2_valid=%0b", out1_valid, out2_valid);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("post rst out1_valid", 32'(out1_valid), 32'd0);
         chk("post rst out2_valid", 32'(out2_valid), 32'd0);
`ifdef DEMUX_COUNT_EN
         chk("post rst cnt1", 32'(cnt1), 32'd0);
         chk("post rst cnt2", 32'(cnt2), 32'd0);
`endif
         tick();
      end

`ifdef DEMUX_COUNT_EN
      // ---------------- counter saturation ----------------
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b1, WIDTH'(i), 1'b1, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      repeat (3) tick();
      chk("sat cnt2", 32'(cnt2), 32'd255);
      chk("sat cnt1", 32'(cnt1), 32'd0);
      $display("saturation: cnt1=%0d cnt2=%0d", cnt1, cnt2);
`endif

      // ---------------- randomized vs reference model ----------------
      do_reset();
      mq1.delete();
      mq2.delete();
      pops1 = 0;
      pops2 = 0;
      for (int i = 0; i < 1500; i++) begin
         rnd_cycle();
      end
      $display("random: 1500 cycles, %0d pops ch1, %0d pops ch2", pops1, pops2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
